// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional back-pressure counter: define PIPE_STALL_CNT_EN to enable stall_cnt.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main holds the output beat, skid invalid
// FULL  | main holds the output beat, skid holds the next beat
module pipe_skid_stage #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            in_ready_q;
  logic            accept;
  logic            drain;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A beat offered alongside flush is dropped; a beat drained alongside it was already delivered.
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end
  end

  // in_ready is registered from next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= RST_VAL;
      skid_q     <= RST_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized self-checking bench for pipe_skid_stage (stall counter checked per PIPE_STALL_CNT_EN).
module tb_pipe_skid_stage;

  localparam int          DW      = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;
`ifdef PIPE_STALL_CNT_EN
  localparam logic [3:0]  SAT_EXP = 4'd15;
  localparam logic [3:0]  MID_EXP = 4'd5;
`else
  localparam logic [3:0]  SAT_EXP = 4'd0;
  localparam logic [3:0]  MID_EXP = 4'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_skid_stage #(.DW(DW), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] nextv;
    logic [31:0] prev_data;
    logic [31:0] exp_d;
    logic        prev_stall;
    int          rx;
    int          cyc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       RST_VAL);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1; tick();
    chk("t1_v1", 32'(out_valid), 32'd1); chk("t1_d1", out_data, 32'h1); chk("t1_r1", 32'(in_ready), 32'd1);
    in_data = 32'h2; tick();
    chk("t1_v2", 32'(out_valid), 32'd1); chk("t1_d2", out_data, 32'h2); chk("t1_r2", 32'(in_ready), 32'd1);
    in_data = 32'h3; tick();
    chk("t1_v3", 32'(out_valid), 32'd1); chk("t1_d3", out_data, 32'h3); chk("t1_r3", 32'(in_ready), 32'd1);
    in_valid = 1'b0; tick();
    chk("t1_empty", 32'(out_valid), 32'd0);

    // Back-pressure into FULL, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    chk("t2_oneA_d", out_data, 32'hA); chk("t2_oneA_r", 32'(in_ready), 32'd1);
    in_data = 32'hB; tick();
    chk("t2_full_r", 32'(in_ready), 32'd0); chk("t2_full_d", out_data, 32'hA);
    in_data = 32'hD; tick();
    chk("t2_hold_r", 32'(in_ready), 32'd0); chk("t2_hold_d", out_data, 32'hA);
    chk("t2_hold_v", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("t2_drainB_d", out_data, 32'hB); chk("t2_drainB_r", 32'(in_ready), 32'd1);
    chk("t2_drainB_v", 32'(out_valid), 32'd1);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Flush from FULL with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    chk("t3_full_r", 32'(in_ready), 32'd0);
    flush = 1'b1; in_data = 32'hC; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_fl_v", 32'(out_valid), 32'd0); chk("t3_fl_r", 32'(in_ready), 32'd1);
    chk("t3_fl_d", out_data, RST_VAL);
    out_ready = 1'b1; tick();
    chk("t3_noC_v", 32'(out_valid), 32'd0);

    // Flush from ONE while a beat is actually accepted
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; tick();
    flush = 1'b1; in_data = 32'hC; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3b_fl_v", 32'(out_valid), 32'd0); chk("t3b_fl_d", out_data, RST_VAL);
    chk("t3b_fl_r", 32'(in_ready), 32'd1);
    tick();
    chk("t3b_noC_v", 32'(out_valid), 32'd0);

    // Reset while holding a beat
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    chk("t4_one_d", out_data, 32'h55);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t4_rst_v", 32'(out_valid), 32'd0); chk("t4_rst_d", out_data, RST_VAL);
    chk("t4_rst_r", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 32'h66; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t4_66_d", out_data, 32'h66); chk("t4_66_v", 32'(out_valid), 32'd1);
    tick();
    chk("t4_alone_v", 32'(out_valid), 32'd0);

    // Random traffic against a FIFO scoreboard
    nextv = 32'h1000_0000; rx = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (rx < 1000 && cyc < 20000) begin
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < 2));
      if (prev_stall) begin
        chk("rnd_stable_v", 32'(out_valid), 32'd1);
        chk("rnd_stable_d", out_data, prev_data);
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = nextv;
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : ~out_data;
        chk("rnd_data", out_data, exp_d);
        rx++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        nextv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      cyc++;
    end
    chk("rnd_count", 32'(rx), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    q.delete();

    // Stall counter saturation, flush retention, reset clear
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("t6_rst_cnt", 32'(stall_cnt), 32'd0);
    in_valid = 1'b1; in_data = 32'h77; tick();
    in_valid = 1'b0;
    chk("t6_start_cnt", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_mid_cnt", 32'(stall_cnt), 32'(MID_EXP));
    for (int i = 0; i < 15; i++) tick();
    chk("t6_sat_cnt", 32'(stall_cnt), 32'(SAT_EXP));
    chk("t6_sat_d", out_data, 32'h77);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("t6_fl_cnt", 32'(stall_cnt), 32'(SAT_EXP));
    chk("t6_fl_v", 32'(out_valid), 32'd0);
    tick();
    chk("t6_idle_cnt", 32'(stall_cnt), 32'(SAT_EXP));
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t6_clr_cnt", 32'(stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register for the core, successor to the fixed hold-only inter-stage flop banks.
- Carries an arbitrary-width payload (a packed decode/control bundle) between two stages.
- Uses a valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Sustains 1 beat/cycle with no combinational path from out_ready to in_ready, so back-pressure can cross stage boundaries without timing loops.

Parameters:
DW, 32, payload width in bits (>=1)
RST_VAL, {DW{1'b0}}, payload value loaded into both data registers on reset/flush
CNT_W, 16, stall counter width (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous flush (pipeline kill, e.g. branch taken)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle (registered)
in_data  in  DW  upstream payload
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DW  payload to downstream (main register)
stall_cnt  out  CNT_W  back-pressure cycle count (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high, named clk and rst as elsewhere in the core.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - Both are sampled at the rising edge.
- Storage:
  - Registers: main (data+valid), skid (data+valid).
  - out_valid = main valid; out_data = main data.
- States and transitions:
  - EMPTY (main invalid, skid invalid):
    - accept -> ONE, main <= in_data.
  - ONE (main valid, skid invalid):
    - accept & drain -> ONE, main <= in_data.
    - accept & !drain -> FULL, skid <= in_data, main held.
    - drain & !accept -> EMPTY.
    - neither -> hold.
  - FULL (both valid):
    - drain -> ONE, main <= skid.
    - else hold.
    - in_valid is ignored.
- in_ready:
  - Register = (next_state != FULL).
  - Never depends combinationally on out_ready or in_valid.
- Latency: in->out 1 cycle. Throughput 1 beat/cycle when out_ready is held high.
- Ordering: strict FIFO; no beat dropped or duplicated except under flush/rst.
- Payload stability: while out_valid & !out_ready, out_data and out_valid are stable.
- After draining to EMPTY, main data retains its last value; out_data is don't-care while out_valid=0.
- flush:
  - Next edge: state -> EMPTY, both data registers <= RST_VAL, in_ready <= 1.
  - A beat offered in the flush cycle is dropped.
  - A beat drained in the flush cycle counts as delivered.
- rst:
  - Overrides flush.
  - Reset values: out_valid=0, out_data=RST_VAL, in_ready=1, stall_cnt=0, state EMPTY.
  - Reset mid-transfer discards all held beats.
- Simultaneous flush & accept in FULL: flush wins; state EMPTY.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle where out_valid & !out_ready.
  - Saturates at all-ones (no wrap).
  - Cleared only by rst; flush does not clear it.
- Undefined:
  - No counter logic; stall_cnt tied to 0.
  - Port list unchanged so instantiations are identical.

Test Plan:
1. DW=32, out_ready=1, stream in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, out_valid continuous, in_ready stays 1.
2. Send 0xA, 0xB with out_ready=0 -> state FULL, in_ready=0 from the cycle after 0xB accepted, out_data=0xA stable; raise out_ready -> 0xA then 0xB delivered, in_ready returns 1 after first drain.
3. FULL holding 0xA,0xB; assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, in_ready=1, out_data=RST_VAL; 0xC never appears.
4. Assert rst for 1 cycle while ONE with 0x55 held -> out_valid=0, out_data=RST_VAL, in_ready=1; next accepted 0x66 emerges alone.
5. Random in_valid/out_ready (50%/50%, 1000 beats, incrementing payload) -> scoreboard: output sequence equals input sequence, no stability violation while stalled.
6. With PIPE_STALL_CNT_EN, CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves 15; rst clears to 0. Without macro -> stall_cnt=0 throughout.
